lfsr_stream: RTL and testbench

- Parametrised Fibonacci LFSR pseudo-random source.
- Successor of the fixed 32-bit free-running generator: configurable width, tap mask, seed and bits per beat.
- Adds a runtime seed load, zero-seed protection, a one-entry valid/ready output register and period/wrap detection.
- Feeds test-pattern and dither consumers that need flow control.

---
 rtl/lfsr_stream.sv | 116 +++++++++++
 tb/tb_lfsr_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR pseudo-random source with runtime seed load, zero-seed protection,
// a one-entry valid/ready output register and period/wrap detection.
module lfsr_stream #(
    parameter int unsigned       WIDTH = 32,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(32'h088C_8892),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(32'h00B5_FFED),
    parameter int unsigned       STEP  = 1,
    parameter int unsigned       CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [STEP-1:0]  out_data_o,
    output logic [WIDTH-1:0] state_o,
    output logic             zero_seed_o,
    output logic             wrap_o,
    output logic [CNT_W-1:0] period_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             valid_q, valid_d;
    logic [STEP-1:0]  data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] period_q, period_d;

    logic [WIDTH-1:0] beat_state_c;
    logic [STEP-1:0]  beat_bits_c;
    logic             advance_c;

    // STEP single shifts unrolled; the first generated feedback bit lands in the MSB.
    always_comb begin
        beat_state_c = state_q;
        beat_bits_c  = '0;
        for (int unsigned k = 0; k < STEP; k++) begin
            beat_bits_c[STEP-1-k] = ^(beat_state_c & TAPS);
            beat_state_c          = {beat_state_c[WIDTH-2:0], beat_bits_c[STEP-1-k]};
        end
    end

    assign advance_c = en_i & (~valid_q | out_ready_i) & ~seed_valid_i;

    // Seed load outranks advance; an unaccepted beat freezes data and state.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        valid_d  = valid_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        wrap_d   = 1'b0;
        period_d = period_q;
        if (seed_valid_i) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            if (seed_i == '0) begin
                state_d = SEED;
                seed_d  = SEED;
                zero_d  = 1'b1;
            end else begin
                state_d = seed_i;
                seed_d  = seed_i;
                zero_d  = 1'b0;
            end
        end else if (advance_c) begin
            state_d = beat_state_c;
            data_d  = beat_bits_c;
            valid_d = 1'b1;
            if (beat_state_c == seed_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + CNT_W'(1);
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= SEED;
            seed_q   <= SEED;
            valid_q  <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            wrap_q   <= 1'b0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            wrap_q   <= wrap_d;
            period_q <= period_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign state_o     = state_q;
    assign zero_seed_o = zero_q;
    assign wrap_o      = wrap_q;
    assign period_o    = period_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: three configurations driven in lockstep against a reference
// model, with transferred beats checked through a per-instance scoreboard queue.
module tb_lfsr_stream;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] state;
    } beat_t;

    localparam int          MW [3] = '{32, 4, 4};
    localparam logic [31:0] MT [3] = '{32'h088C_8892, 32'hC, 32'hC};
    localparam logic [31:0] MS [3] = '{32'h00B5_FFED, 32'h1, 32'h1};
    localparam int          MST[3] = '{1, 1, 4};
    localparam logic [3:0]  SEQ[15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                        4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        en = 1'b0;
    logic        rdy = 1'b0;
    logic        sv = 1'b0;
    logic [31:0] seed = '0;

    logic        d0_valid, d1_valid, d2_valid;
    logic [0:0]  d0_data, d1_data;
    logic [3:0]  d2_data;
    logic [31:0] d0_state;
    logic [3:0]  d1_state, d2_state;
    logic        d0_zero, d1_zero, d2_zero;
    logic        d0_wrap, d1_wrap, d2_wrap;
    logic [31:0] d0_period, d1_period, d2_period;

    logic        act_valid[3], act_wrap[3], act_zero[3];
    logic [31:0] act_state[3], act_data[3], act_period[3];

    logic [31:0] m_state[3], m_seed[3], m_data[3], m_cnt[3], m_period[3];
    logic        m_valid[3], m_zero[3], m_wrap[3];
    beat_t       sbq[3][$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_stream u_d0 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en), .seed_valid_i(sv), .seed_i(seed),
        .out_valid_o(d0_valid), .out_ready_i(rdy), .out_data_o(d0_data), .state_o(d0_state),
        .zero_seed_o(d0_zero), .wrap_o(d0_wrap), .period_o(d0_period)
    );

    lfsr_stream #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .STEP(1), .CNT_W(32)) u_d1 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en), .seed_valid_i(sv), .seed_i(seed[3:0]),
        .out_valid_o(d1_valid), .out_ready_i(rdy), .out_data_o(d1_data), .state_o(d1_state),
        .zero_seed_o(d1_zero), .wrap_o(d1_wrap), .period_o(d1_period)
    );

    lfsr_stream #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .STEP(4), .CNT_W(32)) u_d2 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en), .seed_valid_i(sv), .seed_i(seed[3:0]),
        .out_valid_o(d2_valid), .out_ready_i(rdy), .out_data_o(d2_data), .state_o(d2_state),
        .zero_seed_o(d2_zero), .wrap_o(d2_wrap), .period_o(d2_period)
    );

    assign act_valid[0] = d0_valid;  assign act_valid[1] = d1_valid;  assign act_valid[2] = d2_valid;
    assign act_wrap[0]  = d0_wrap;   assign act_wrap[1]  = d1_wrap;   assign act_wrap[2]  = d2_wrap;
    assign act_zero[0]  = d0_zero;   assign act_zero[1]  = d1_zero;   assign act_zero[2]  = d2_zero;
    assign act_state[0] = d0_state;  assign act_state[1] = 32'(d1_state); assign act_state[2] = 32'(d2_state);
    assign act_data[0]  = 32'(d0_data); assign act_data[1] = 32'(d1_data); assign act_data[2] = 32'(d2_data);
    assign act_period[0] = d0_period; assign act_period[1] = d1_period; assign act_period[2] = d2_period;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void lfsr_beat(input logic [31:0] s, input int w, input logic [31:0] taps,
                                      input int st, output logic [31:0] ns, output logic [31:0] d);
        logic [63:0] msk;
        logic        fb;
        msk = (64'd1 << w) - 64'd1;
        ns  = s;
        d   = '0;
        for (int k = 0; k < st; k++) begin
            fb = ^(ns & taps);
            ns = ((ns << 1) | 32'(fb)) & msk[31:0];
            d  = (d << 1) | 32'(fb);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_state[i] = MS[i]; m_seed[i] = MS[i]; m_data[i] = '0; m_cnt[i] = '0;
            m_period[i] = '0; m_valid[i] = 1'b0; m_zero[i] = 1'b0; m_wrap[i] = 1'b0;
            sbq[i].delete();
        end
    endtask

    // Predicts the effect of the coming clock edge from the inputs currently driven.
    task automatic model_step(input int i);
        logic [63:0] msk;
        logic [31:0] ns, d;
        msk = (64'd1 << MW[i]) - 64'd1;
        m_wrap[i] = 1'b0;
        if (sv) begin
            sbq[i].delete();
            m_valid[i] = 1'b0;
            m_cnt[i]   = '0;
            if ((seed & msk[31:0]) == '0) begin
                m_state[i] = MS[i]; m_seed[i] = MS[i]; m_zero[i] = 1'b1;
            end else begin
                m_state[i] = seed & msk[31:0]; m_seed[i] = seed & msk[31:0]; m_zero[i] = 1'b0;
            end
        end else if (en && (!m_valid[i] || rdy)) begin
            lfsr_beat(m_state[i], MW[i], MT[i], MST[i], ns, d);
            m_state[i] = ns;
            m_data[i]  = d;
            m_valid[i] = 1'b1;
            sbq[i].push_back('{data: d, state: ns});
            if (ns == m_seed[i]) begin
                m_wrap[i]   = 1'b1;
                m_period[i] = m_cnt[i] + 32'd1;
                m_cnt[i]    = '0;
            end else begin
                m_cnt[i] = m_cnt[i] + 32'd1;
            end
        end else if (m_valid[i] && rdy) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d valid", i), 32'(act_valid[i]), 32'(m_valid[i]));
            check($sformatf("d%0d state", i), act_state[i], m_state[i]);
            check($sformatf("d%0d wrap", i), 32'(act_wrap[i]), 32'(m_wrap[i]));
            check($sformatf("d%0d period", i), act_period[i], m_period[i]);
            check($sformatf("d%0d zero_seed", i), 32'(act_zero[i]), 32'(m_zero[i]));
            if (m_valid[i]) check($sformatf("d%0d data", i), act_data[i], m_data[i]);
        end
    endtask

    // One clock: score any transfer, advance the model, then sample after the edge.
    task automatic cycle();
        beat_t b;
        for (int i = 0; i < 3; i++) begin
            if (act_valid[i] && rdy) begin
                check($sformatf("d%0d sb depth", i), 32'(sbq[i].size()), 32'd1);
                if (sbq[i].size() > 0) begin
                    b = sbq[i].pop_front();
                    check($sformatf("d%0d sb data", i), act_data[i], b.data);
                    check($sformatf("d%0d sb state", i), act_state[i], b.state);
                end
            end
        end
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        en = 1'b0; rdy = 1'b0; sv = 1'b0; seed = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] frozen;

        // Reset defaults and first beat
        do_reset();
        check("reset state", d0_state, 32'h00B5_FFED);
        en = 1'b1; rdy = 1'b1;
        cycle();
        check("first state", d0_state, 32'h016B_FFDB);
        check("first data", 32'(d0_data), 32'd1);
        check("first valid", 32'(d0_valid), 32'd1);
        check("step4 state", 32'(d2_state), 32'h3);
        check("step4 data", 32'(d2_data), 32'h3);

        // Full period of the 4-bit generator, twice
        do_reset();
        en = 1'b1; rdy = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            cycle();
            check($sformatf("seq beat %0d", n), 32'(d1_state), 32'(SEQ[n % 15]));
            check($sformatf("seq wrap %0d", n), 32'(d1_wrap), 32'(n % 15 == 0));
            if (n == 15) check("period 15", d1_period, 32'd15);
        end

        // Backpressure: beat must freeze, then drain one per cycle
        rdy = 1'b0;
        cycle();
        frozen = d0_state;
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("frozen state", d0_state, frozen);
        end
        rdy = 1'b1;
        for (int n = 0; n < 10; n++) cycle();

        // Random enable/ready mix
        for (int n = 0; n < 80; n++) begin
            en  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 3) != 0);
            cycle();
        end

        // Zero seed substitutes SEED; next nonzero load clears the flag
        sv = 1'b1; seed = '0; en = 1'b1; rdy = 1'b1;
        cycle();
        check("zero seed state", 32'(d1_state), 32'h1);
        check("zero seed flag", 32'(d1_zero), 32'd1);
        check("zero seed valid", 32'(d1_valid), 32'd0);
        seed = 32'h5;
        cycle();
        check("seed5 state", 32'(d1_state), 32'h5);
        check("seed5 flag", 32'(d1_zero), 32'd0);
        sv = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            cycle();
            check($sformatf("seed5 wrap %0d", n), 32'(d1_wrap), 32'(n == 15));
        end
        check("seed5 period", d1_period, 32'd15);

        // Seed load wins over a simultaneous advance
        for (int n = 0; n < 3; n++) cycle();
        sv = 1'b1; seed = 32'h9;
        cycle();
        check("seed wins valid", 32'(d1_valid), 32'd0);
        check("seed wins state", 32'(d1_state), 32'h9);
        sv = 1'b0;
        for (int n = 0; n < 20; n++) cycle();

        // Asynchronous reset between clock edges
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        check("async reset state", d0_state, 32'h00B5_FFED);
        check("async reset valid", 32'(d0_valid), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int n = 0; n < 5; n++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
